// File: rtl/ram_ctrl_pkg.sv
// Shared widths and state encoding for the burst RAM controller and its read buffer.
package ram_ctrl_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_LEN_W  = 4;
  localparam int RAM_DEPTH  = 2**DEF_ADDR_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2
  } state_t;
endpackage

// File: rtl/rd_skid_fifo.sv
// Two-entry FIFO holding RAM read returns; data visible the cycle after push.
// Push while full is honoured only together with a pop; the producer must respect count.
module rd_skid_fifo
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_dat,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_pop_dat,
  output logic              o_full,
  output logic              o_empty,
  output logic [1:0]        o_count
);
  logic [DATA_W-1:0] r_mem [2];
  logic              r_wptr;
  logic              r_rptr;
  logic [1:0]        r_count;
  logic              w_push;
  logic              w_pop;

  assign o_full    = (r_count == 2'd2);
  assign o_empty   = (r_count == 2'd0);
  assign o_count   = r_count;
  assign o_pop_dat = r_mem[r_rptr];
  assign w_pop     = i_pop && !o_empty;
  assign w_push    = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wptr  <= 1'b0;
      r_rptr  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_push_dat;
  end
endmodule

// File: rtl/ram_burst_ctrl.sv
// Burst read/write initiator for a single-port RAM with one-cycle registered-address reads.
// Writes are combinational pass-through; reads return via a 2-entry buffer, issue throttled by buffer space.
module ram_burst_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [LEN_W-1:0]  i_cmd_len,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [DATA_W-1:0] i_wr_data,
  output logic              o_rd_valid,
  input  logic              i_rd_ready,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_busy,
  output logic [DATA_W-1:0] o_ram_data,
  output logic [ADDR_W-1:0] o_ram_addr,
  output logic              o_ram_we,
  input  logic [DATA_W-1:0] i_ram_q
);
  localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
  localparam logic [LEN_W-1:0]  LEN_ONE  = 1;

  state_t            r_state, w_state_nxt;
  logic [ADDR_W-1:0] r_cur_addr, w_cur_addr_nxt;
  logic [LEN_W-1:0]  r_remaining, w_remaining_nxt;
  logic              r_inflight;
  logic              w_issue;
  logic              w_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [1:0]        w_fifo_count;
  logic [1:0]        w_occupancy;
  logic [DATA_W-1:0] w_fifo_head;

  // A read may only launch if its data is guaranteed a buffer slot on return.
  assign w_occupancy = w_fifo_count + {1'b0, r_inflight};

  always_comb begin
    w_state_nxt     = r_state;
    w_cur_addr_nxt  = r_cur_addr;
    w_remaining_nxt = r_remaining;
    o_cmd_ready     = 1'b0;
    o_wr_ready      = 1'b0;
    o_ram_we        = 1'b0;
    o_ram_data      = '0;
    o_ram_addr      = r_cur_addr;
    w_issue         = 1'b0;
    if (i_rst) begin
      o_ram_addr = '0;
    end else begin
      case (r_state)
        IDLE: begin
          o_cmd_ready = !r_inflight;
          if (i_cmd_valid && !r_inflight) begin
            w_cur_addr_nxt  = i_cmd_addr;
            w_remaining_nxt = i_cmd_len;
            w_state_nxt     = i_cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          o_wr_ready = 1'b1;
          o_ram_data = i_wr_data;
          o_ram_we   = i_wr_valid;
          if (i_wr_valid) begin
            w_cur_addr_nxt = r_cur_addr + ADDR_ONE;
            if (r_remaining == '0) w_state_nxt = IDLE;
            else                   w_remaining_nxt = r_remaining - LEN_ONE;
          end
        end
        READ: begin
          w_issue = !w_fifo_full && (w_occupancy < 2'd2);
          if (w_issue) begin
            w_cur_addr_nxt = r_cur_addr + ADDR_ONE;
            if (r_remaining == '0) w_state_nxt = IDLE;
            else                   w_remaining_nxt = r_remaining - LEN_ONE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_cur_addr  <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_addr  <= w_cur_addr_nxt;
      r_remaining <= w_remaining_nxt;
      r_inflight  <= w_issue;
    end
  end

  assign o_rd_valid = !i_rst && !w_fifo_empty;
  assign o_rd_data  = w_fifo_head;
  assign w_pop      = o_rd_valid && i_rd_ready;
  assign o_busy     = !i_rst && ((r_state != IDLE) || r_inflight);

  rd_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_rd_fifo (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_push     (r_inflight),
    .i_push_dat (i_ram_q),
    .i_pop      (w_pop),
    .o_pop_dat  (w_fifo_head),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty),
    .o_count    (w_fifo_count)
  );
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Scoreboard bench for ram_burst_ctrl with a behavioural 64x8 registered-address RAM.
module tb_ram_burst_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_write;
  logic [5:0] cmd_addr;
  logic [3:0] cmd_len;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       busy;
  logic [7:0] ram_data, ram_q;
  logic [5:0] ram_addr;
  logic       ram_we;

  always #5 clk = ~clk;

  ram_burst_ctrl dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_write(cmd_write),
    .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready), .i_wr_data(wr_data),
    .o_rd_valid(rd_valid), .i_rd_ready(rd_ready), .o_rd_data(rd_data),
    .o_busy(busy),
    .o_ram_data(ram_data), .o_ram_addr(ram_addr), .o_ram_we(ram_we), .i_ram_q(ram_q)
  );

  // RAM model: address register only loads on non-write edges
  logic [7:0] mem [64];
  logic [5:0] mem_areg;
  logic       mem_clr;
  always @(posedge clk) begin
    if (mem_clr) begin
      for (int k = 0; k < 64; k++) mem[k] <= 8'h00;
      mem_areg <= '0;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_data;
    end else begin
      mem_areg <= ram_addr;
    end
  end
  assign ram_q = mem[mem_areg];

  int checks = 0;
  int failures = 0;
  int we_cnt = 0;
  logic [7:0]  ref_mem [64];
  logic [7:0]  wdat [16];
  logic [13:0] wr_exp [$];
  logic [7:0]  rd_exp [$];
  logic [13:0] wr_e;
  logic [7:0]  rd_e;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (ram_we) begin
      we_cnt++;
      if (wr_exp.size() == 0) chk_eq("wr_unexpected", 32'(ram_we), 0);
      else begin
        wr_e = wr_exp.pop_front();
        chk_eq("wr_addr", 32'(ram_addr), 32'(wr_e[13:8]));
        chk_eq("wr_data", 32'(ram_data), 32'(wr_e[7:0]));
      end
    end
    if (rd_valid && rd_ready) begin
      if (rd_exp.size() == 0) chk_eq("rd_unexpected", 32'(rd_valid), 0);
      else begin
        rd_e = rd_exp.pop_front();
        chk_eq("rd_data", 32'(rd_data), 32'(rd_e));
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog t=%0t limit=400000", $time);
    $fatal(1, "watchdog");
  end

  // Called and returns just after a rising edge.
  task automatic send_cmd(input logic w, input logic [5:0] a, input logic [3:0] l);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_len = l;
    @(negedge clk);
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk_eq("cmd_accept_bound", 32'(n < 200), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic write_burst(input logic [5:0] a, input logic [3:0] l, input logic [31:0] gaps);
    int beat, c;
    logic [5:0] ad;
    for (int i = 0; i <= int'(l); i++) begin
      ad = a + 6'(i);
      wr_exp.push_back({ad, wdat[i]});
      ref_mem[ad] = wdat[i];
    end
    send_cmd(1'b1, a, l);
    beat = 0; c = 0;
    while (beat <= int'(l) && c < 32) begin
      wr_valid = !gaps[c];
      wr_data  = gaps[c] ? 8'hEE : wdat[beat];
      @(negedge clk);
      chk_eq("wr_cmd_ready_low", 32'(cmd_ready), 0);
      if (gaps[c]) chk_eq("wr_gap_no_we", 32'(ram_we), 0);
      else         chk_eq("wr_ready_high", 32'(wr_ready), 1);
      if (wr_valid && wr_ready) beat++;
      c++;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0; wr_data = '0;
    chk_eq("wr_beats_done", 32'(beat), 32'(int'(l) + 1));
    @(negedge clk);
    chk_eq("wr_end_cmd_ready", 32'(cmd_ready), 1);
    chk_eq("wr_exp_drained", 32'(wr_exp.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic rd_push(input logic [5:0] a, input logic [3:0] l);
    logic [5:0] ad;
    for (int i = 0; i <= int'(l); i++) begin
      ad = a + 6'(i);
      rd_exp.push_back(ref_mem[ad]);
    end
  endtask

  task automatic rd_drain();
    int n;
    n = 0;
    while ((rd_exp.size() != 0 || busy) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk_eq("rd_drain_bound", 32'(n < 500), 1);
    @(negedge clk);
    chk_eq("rd_idle_no_valid", 32'(rd_valid), 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int  n;
    bit  got;
    int  c0;
    rst = 1'b1; mem_clr = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b1;
    for (int k = 0; k < 64; k++) ref_mem[k] = 8'h00;

    // Reset values
    repeat (2) @(posedge clk);
    #1; mem_clr = 1'b0;
    @(negedge clk);
    chk_eq("rst_rd_valid", 32'(rd_valid), 0);
    chk_eq("rst_ram_we", 32'(ram_we), 0);
    chk_eq("rst_wr_ready", 32'(wr_ready), 0);
    chk_eq("rst_busy", 32'(busy), 0);
    chk_eq("rst_ram_addr", 32'(ram_addr), 0);
    chk_eq("rst_ram_data", 32'(ram_data), 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk_eq("post_rst_cmd_ready", 32'(cmd_ready), 1);
    @(posedge clk); #1;

    // Single write then read with latency check
    wdat[0] = 8'hA5;
    c0 = we_cnt;
    write_burst(6'd5, 4'd0, 32'd0);
    chk_eq("single_we_cycles", 32'(we_cnt - c0), 1);
    rd_push(6'd5, 4'd0);
    send_cmd(1'b0, 6'd5, 4'd0);
    @(negedge clk);
    chk_eq("rd_lat_c1_valid", 32'(rd_valid), 0);
    chk_eq("rd_lat_c1_addr", 32'(ram_addr), 5);
    @(negedge clk);
    chk_eq("rd_lat_c2_valid", 32'(rd_valid), 0);
    @(negedge clk);
    chk_eq("rd_lat_c3_valid", 32'(rd_valid), 1);
    chk_eq("rd_lat_c3_data", 32'(rd_data), 32'h A5);
    @(posedge clk); #1;
    rd_drain();

    // Address wrap
    for (int i = 0; i < 4; i++) wdat[i] = 8'(i + 1);
    write_burst(6'd62, 4'd3, 32'd0);
    rd_push(6'd62, 4'd3);
    send_cmd(1'b0, 6'd62, 4'd3);
    rd_drain();

    // Read backpressure
    for (int i = 0; i < 16; i++) wdat[i] = 8'(i * 3);
    write_burst(6'd0, 4'd15, 32'd0);
    rd_ready = 1'b0;
    rd_push(6'd0, 4'd15);
    send_cmd(1'b0, 6'd0, 4'd15);
    repeat (10) @(negedge clk);
    chk_eq("bp_ram_addr_frozen", 32'(ram_addr), 2);
    chk_eq("bp_rd_valid", 32'(rd_valid), 1);
    chk_eq("bp_rd_data_head", 32'(rd_data), 0);
    chk_eq("bp_nothing_popped", 32'(rd_exp.size()), 16);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    rd_drain();

    // Write gaps: valid pattern 1,0,0,1,1
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33;
    c0 = we_cnt;
    write_burst(6'd40, 4'd2, 32'b00110);
    chk_eq("gap_we_cycles", 32'(we_cnt - c0), 3);
    rd_push(6'd40, 4'd2);
    send_cmd(1'b0, 6'd40, 4'd2);
    rd_drain();

    // Reset during beat 2 of an 8-beat write
    for (int i = 0; i < 8; i++) wdat[i] = 8'(8'h80 + i);
    wr_exp.push_back({6'd20, wdat[0]});
    wr_exp.push_back({6'd21, wdat[1]});
    ref_mem[20] = wdat[0];
    ref_mem[21] = wdat[1];
    send_cmd(1'b1, 6'd20, 4'd7);
    for (int b = 0; b < 2; b++) begin
      wr_valid = 1'b1; wr_data = wdat[b];
      @(negedge clk);
      @(posedge clk); #1;
    end
    wr_valid = 1'b1; wr_data = wdat[2]; rst = 1'b1;
    @(negedge clk);
    chk_eq("midrst_no_we", 32'(ram_we), 0);
    chk_eq("midrst_busy", 32'(busy), 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk_eq("after_rst_cmd_ready", 32'(cmd_ready), 1);
    chk_eq("after_rst_busy", 32'(busy), 0);
    chk_eq("after_rst_rd_valid", 32'(rd_valid), 0);
    chk_eq("after_rst_no_we", 32'(ram_we), 0);
    chk_eq("after_rst_wr_ready", 32'(wr_ready), 0);
    @(posedge clk); #1; wr_valid = 1'b0;
    chk_eq("midrst_wr_exp_drained", 32'(wr_exp.size()), 0);
    rd_push(6'd20, 4'd3);
    send_cmd(1'b0, 6'd20, 4'd3);
    rd_drain();

    // Command held valid across a read burst
    rd_push(6'd0, 4'd7);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 6'd0; cmd_len = 4'd7;
    @(negedge clk);
    chk_eq("held_first_ready", 32'(cmd_ready), 1);
    @(posedge clk); #1;
    cmd_addr = 6'd5; cmd_len = 4'd0;
    rd_push(6'd5, 4'd0);
    n = 0; got = 1'b0;
    while (!got && n < 100) begin
      @(negedge clk);
      chk_eq("held_ready_vs_busy", 32'(cmd_ready), 32'(!busy));
      if (cmd_ready) got = 1'b1;
      else begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk_eq("held_wait_ge8", 32'(n >= 8), 1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk_eq("held_second_accepted", 32'(busy), 1);
    @(posedge clk); #1;
    rd_drain();

    chk_eq("final_wr_exp_empty", 32'(wr_exp.size()), 0);
    chk_eq("final_rd_exp_empty", 32'(rd_exp.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ram_burst_ctrl.md
Name: ram_burst_ctrl

Overview:
Initiator-side controller for the 64x8 single-port RAM. It accepts burst read/write commands over valid/ready handshakes and drives the RAM's data/addr/we pins. For writes it streams write data in. For reads it captures the RAM's q output and streams it back with backpressure. It sits between the system-side requester and the single-port RAM instance.

Parameters:
DATA_W, 8, RAM word width
ADDR_W, 6, RAM address width (depth 2**ADDR_W = 64)
LEN_W, 4, burst length field width; beats = cmd_len+1 (1..16)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
cmd_valid  in  1  command request valid
cmd_ready  out  1  controller accepts command
cmd_write  in  1  1=write burst, 0=read burst
cmd_addr  in  ADDR_W  burst start address
cmd_len  in  LEN_W  beats minus one
wr_valid  in  1  write beat valid
wr_ready  out  1  write beat accepted
wr_data  in  DATA_W  write beat data
rd_valid  out  1  read beat valid
rd_ready  in  1  read beat consumed
rd_data  out  DATA_W  read beat data
busy  out  1  state != IDLE or read in flight
ram_data  out  DATA_W  to RAM data
ram_addr  out  ADDR_W  to RAM addr
ram_we  out  1  to RAM we
ram_q  in  DATA_W  from RAM q

Behaviour:
- Reset (rst=1 at edge): state=IDLE, beat counter=0, cur_addr=0, inflight=0, read buffer empty. Outputs while/after reset: rd_valid=0, ram_we=0, wr_ready=0, busy=0, ram_addr=0, ram_data=0. cmd_ready=1 from the first cycle after reset.
- Reset mid-burst aborts immediately: no further ram_we, buffered read data discarded, no partial-burst completion.
- FSM states: IDLE, WRITE, READ.
- IDLE: cmd_ready = (inflight==0). On cmd_valid&&cmd_ready: latch cur_addr=cmd_addr and remaining=cmd_len, then go to WRITE or READ per cmd_write. Commands are never accepted outside IDLE.
- WRITE:
  - wr_ready=1; ram_addr=cur_addr; ram_data=wr_data; ram_we=wr_valid (all combinational).
  - Each accepted beat increments cur_addr and decrements remaining.
  - Beat accepted with remaining==0 -> IDLE.
  - Gaps (wr_valid=0) hold state and keep ram_we=0.
- READ:
  - ram_we=0; ram_addr=cur_addr.
  - Issue condition: buffer_count + inflight < 2.
  - On issue: inflight=1 for the next cycle, then increment cur_addr and decrement remaining.
  - On the edge after an issue, ram_q is pushed into the read buffer (RAM has one-cycle read latency via its address register).
  - Last issue (remaining==0) -> IDLE. busy stays 1 until inflight clears.
  - When not issuing, ram_addr still shows cur_addr. This is harmless, since the RAM address register updates on every non-write edge.
- Read buffer:
  - 2-entry FIFO; rd_valid = !empty; rd_data = head.
  - Pops on rd_valid&&rd_ready.
  - Push and pop in the same cycle are legal when full.
  - Zero-bubble streaming whenever rd_ready=1.
- Address arithmetic: cur_addr+1 is modulo 2**ADDR_W (63 -> 0). remaining is unsigned and never underflows.
- wr_valid outside WRITE is ignored (wr_ready=0, no write).
- Read data order equals issue order. A write command cannot start before all reads of the prior burst have been captured, which preserves read-before-write ordering.

Decomposition:
- Package ram_ctrl_pkg:
  - DATA_W, ADDR_W, LEN_W defaults
  - enum state_t {IDLE, WRITE, READ}
  - RAM_DEPTH = 2**ADDR_W
- Sub-module rd_skid_fifo (2-entry, DATA_W wide; push/pop/full/empty/count) holds read return data.

Test Plan:
- Single write then read: write 0xA5 to addr 5 (len 0), then read addr 5 -> ram_we high for exactly one cycle with addr 5; rd_data=0xA5 with rd_valid two cycles after read command accept.
- Wrap burst: write len 3 at addr 62 with data 1,2,3,4 -> RAM writes at 62,63,0,1. Read back len 3 from 62 -> 1,2,3,4 in order.
- Read backpressure: fill 0..15 with i*3, read len 15 with rd_ready=0 for 10 cycles -> exactly 2 issues, rd_valid=1 holds data 0, ram_addr frozen at 2. After release, all 16 values arrive in order, no loss or duplication.
- Write gaps: len 2 write with wr_valid pattern 1,0,0,1,1 -> ram_we only on the 3 valid cycles at consecutive addresses; cmd_ready=0 until the third beat.
- Reset mid-burst: assert rst during beat 2 of a len 7 write -> no ram_we afterwards, rd_valid=0, busy=0, cmd_ready=1 the cycle after rst deasserts. Only beats 0-1 are present in the RAM.
- Command during busy: cmd_valid held throughout a read burst -> cmd_ready=0 until state=IDLE and inflight=0, then accepted exactly once.
